// File: rtl/amstrad_mem_pkg.sv
// ============================================================================
// Package     : amstrad_mem_pkg
// Description : Shared constants, loader state encoding and address helper
//               for the Amstrad ROM download path into SDRAM.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package amstrad_mem_pkg;

    // Byte address width of the SDRAM RAM/ROM space
    localparam int MEM_AW    = 23;
    // Byte offset width inside one 16KB ROM image
    localparam int ROM_OFS_W = 14;
    // One FIFO entry holds {offset, data}
    localparam int FIFO_W    = ROM_OFS_W + 8;

    // Lower ROM lives at the bottom of memory, upper ROMs in the top half
    localparam logic [8:0] LOWER_ROM_PREFIX = 9'b0;
    localparam logic       UPPER_ROM_FLAG   = 1'b1;

    // Loader states
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LOAD   = 2'd1,
        S_DRAIN  = 2'd2,
        S_COMMIT = 2'd3
    } loader_state_e;

    localparam logic [1:0] ST_IDLE   = S_IDLE;
    localparam logic [1:0] ST_LOAD   = S_LOAD;
    localparam logic [1:0] ST_DRAIN  = S_DRAIN;
    localparam logic [1:0] ST_COMMIT = S_COMMIT;

    // Map a ROM byte offset to its SDRAM byte address
    function automatic logic [MEM_AW-1:0] rom_byte_addr(
        input logic                 lower,
        input logic [7:0]           bank,
        input logic [ROM_OFS_W-1:0] ofs
    );
        if (lower) begin
            rom_byte_addr = {LOWER_ROM_PREFIX, ofs};
        end else begin
            rom_byte_addr = {UPPER_ROM_FLAG, bank, ofs};
        end
    endfunction

endpackage

`default_nettype wire

// File: rtl/amstrad_loader_fifo.sv
// ============================================================================
// Module      : amstrad_loader_fifo
// Description : Synchronous first-word-fall-through FIFO for downloaded ROM
//               bytes. A pop and a push in the same cycle are both honoured,
//               including when the FIFO is full (pop frees the slot first).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module amstrad_loader_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 22
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      rd_ptr_q;
    logic             w_do_pop;
    logic             w_do_push;

    // Extra pointer bit distinguishes full from empty
    assign empty_o   = (wr_ptr_q == rd_ptr_q);
    assign full_o    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                       (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign w_do_pop  = pop_i && !empty_o;
    assign w_do_push = push_i && (!full_o || w_do_pop);
    assign data_o    = mem_q[rd_ptr_q[AW-1:0]];

    // Pointer bookkeeping; reset flushes the contents
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (w_do_push) begin
                wr_ptr_q <= wr_ptr_q + {{AW{1'b0}}, 1'b1};
            end
            if (w_do_pop) begin
                rd_ptr_q <= rd_ptr_q + {{AW{1'b0}}, 1'b1};
            end
        end
    end

    // Entry storage, written at the tail
    always_ff @(posedge clk_i) begin
        if (w_do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= data_i;
        end
    end

endmodule

`default_nettype wire

// File: rtl/amstrad_rom_loader.sv
// ============================================================================
// Module      : amstrad_rom_loader
// Description : Accepts a byte-stream ROM download, buffers it and writes it
//               into SDRAM through a level/ack request port. Tracks which
//               upper ROM banks hold a complete image in rom_map.
//               Optional macro ROM_CHECKSUM_EN adds rom_sum/rom_sum_valid,
//               an 8-bit sum of the bytes acknowledged by memory.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module amstrad_rom_loader
    import amstrad_mem_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic          CLK,
    input  logic          reset,
    input  logic          dl_active,
    input  logic          dl_lower,
    input  logic [7:0]    dl_bank,
    input  logic          dl_wr,
    input  logic [13:0]   dl_addr,
    input  logic [7:0]    dl_data,
    output logic          dl_wait,
    output logic          mem_wr,
    output logic [22:0]   mem_A,
    output logic [7:0]    mem_D,
    input  logic          mem_ack,
    output logic [255:0]  rom_map,
    output logic          ovf
`ifdef ROM_CHECKSUM_EN
    ,
    output logic [7:0]    rom_sum,
    output logic          rom_sum_valid
`endif
);

    logic [1:0]        state_q, state_d;
    logic              active_q;
    logic              lower_q, lower_d;
    logic [7:0]        bank_q, bank_d;
    logic              got_q, got_d;
    logic              ovf_q, ovf_d;
    logic [255:0]      map_q, map_d;
    logic              cool_q;

    logic              w_rise;
    logic              w_pop;
    logic              w_push;
    logic              w_full;
    logic              w_empty;
    logic [FIFO_W-1:0] w_head;

    assign w_rise = dl_active && !active_q;

    // Only a request actually on the bus can be acknowledged
    assign w_pop  = mem_wr && mem_ack;

    // A pop in the same cycle frees a slot, so a full FIFO can still take a byte
    always_comb begin
        dl_wait = 1'b0;
        case (state_q)
            ST_LOAD:   dl_wait = w_full && !w_pop;
            ST_DRAIN,
            ST_COMMIT: dl_wait = 1'b1;
            default:   dl_wait = 1'b0;
        endcase
    end

    assign w_push = (state_q == ST_LOAD) && dl_wr && !dl_wait;

    amstrad_loader_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (FIFO_W)
    ) u_fifo (
        .clk_i   (CLK),
        .rst_i   (reset),
        .push_i  (w_push),
        .data_i  ({dl_addr, dl_data}),
        .pop_i   (w_pop),
        .data_o  (w_head),
        .full_o  (w_full),
        .empty_o (w_empty)
    );

    // Request straight from the FIFO head; one idle cycle follows every ack
    assign mem_wr  = !w_empty && !cool_q;
    assign mem_A   = mem_wr ? rom_byte_addr(lower_q, bank_q, w_head[FIFO_W-1:8]) : '0;
    assign mem_D   = mem_wr ? w_head[7:0] : '0;
    assign rom_map = map_q;
    assign ovf     = ovf_q;

    // Transfer sequencing, overflow flag and bank-presence bookkeeping
    always_comb begin
        state_d = state_q;
        lower_d = lower_q;
        bank_d  = bank_q;
        got_d   = got_q;
        ovf_d   = ovf_q;
        map_d   = map_q;
        if (dl_wr && dl_wait) begin
            ovf_d = 1'b1;
        end
        case (state_q)
            ST_IDLE: begin
                if (w_rise) begin
                    state_d = ST_LOAD;
                    lower_d = dl_lower;
                    bank_d  = dl_bank;
                    got_d   = 1'b0;
                    ovf_d   = 1'b0;
                    // Bank is invalid until its new image is complete
                    if (!dl_lower) begin
                        map_d[dl_bank] = 1'b0;
                    end
                end
            end
            ST_LOAD: begin
                if (w_push) begin
                    got_d = 1'b1;
                end
                if (!dl_active) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // Empty FIFO also means no request is outstanding
                if (w_empty) begin
                    state_d = ST_COMMIT;
                end
            end
            ST_COMMIT: begin
                if (!lower_q && got_q) begin
                    map_d[bank_q] = 1'b1;
                end
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State registers
    always_ff @(posedge CLK) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            active_q <= 1'b0;
            lower_q  <= 1'b0;
            bank_q   <= 8'd0;
            got_q    <= 1'b0;
            ovf_q    <= 1'b0;
            map_q    <= 256'h1;
            cool_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            active_q <= dl_active;
            lower_q  <= lower_d;
            bank_q   <= bank_d;
            got_q    <= got_d;
            ovf_q    <= ovf_d;
            map_q    <= map_d;
            cool_q   <= w_pop;
        end
    end

`ifdef ROM_CHECKSUM_EN
    logic [7:0] sum_q;
    logic       sum_valid_q;

    assign rom_sum       = sum_q;
    assign rom_sum_valid = sum_valid_q;

    // Running sum of acknowledged bytes, published once the transfer commits
    always_ff @(posedge CLK) begin
        if (reset) begin
            sum_q       <= 8'd0;
            sum_valid_q <= 1'b0;
        end else if (state_q == ST_IDLE && w_rise) begin
            sum_q       <= 8'd0;
            sum_valid_q <= 1'b0;
        end else begin
            if (w_pop) begin
                sum_q <= sum_q + mem_D;
            end
            if (state_q == ST_DRAIN && w_empty) begin
                sum_valid_q <= 1'b1;
            end
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_amstrad_rom_loader.sv
// ============================================================================
// Module      : tb_amstrad_rom_loader
// Description : Self-checking bench for amstrad_rom_loader. A queue-based
//               model predicts every output each cycle; directed scenarios
//               pin known addresses/data, then randomized transfers run.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_amstrad_rom_loader;

    localparam int DEPTH   = 4;
    localparam int P_IDLE  = 0;
    localparam int P_LOAD  = 1;
    localparam int P_DRAIN = 2;
    localparam int P_COMM  = 3;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         dl_active = 1'b0;
    logic         dl_lower = 1'b0;
    logic [7:0]   dl_bank = 8'd0;
    logic         dl_wr = 1'b0;
    logic [13:0]  dl_addr = 14'd0;
    logic [7:0]   dl_data = 8'd0;
    logic         mem_ack = 1'b0;
    logic         dl_wait;
    logic         mem_wr;
    logic [22:0]  mem_A;
    logic [7:0]   mem_D;
    logic [255:0] rom_map;
    logic         ovf;
`ifdef ROM_CHECKSUM_EN
    logic [7:0]   rom_sum;
    logic         rom_sum_valid;
`endif

    always #5 clk = ~clk;

    amstrad_rom_loader #(.FIFO_DEPTH(DEPTH)) dut (
        .CLK       (clk),
        .reset     (reset),
        .dl_active (dl_active),
        .dl_lower  (dl_lower),
        .dl_bank   (dl_bank),
        .dl_wr     (dl_wr),
        .dl_addr   (dl_addr),
        .dl_data   (dl_data),
        .dl_wait   (dl_wait),
        .mem_wr    (mem_wr),
        .mem_A     (mem_A),
        .mem_D     (mem_D),
        .mem_ack   (mem_ack),
        .rom_map   (rom_map),
        .ovf       (ovf)
`ifdef ROM_CHECKSUM_EN
        ,
        .rom_sum       (rom_sum),
        .rom_sum_valid (rom_sum_valid)
`endif
    );

    int vectors = 0;
    int miscompares = 0;

    // Behavioural model state
    int           m_phase = P_IDLE;
    logic [21:0]  m_q[$];
    bit           m_cool, m_lower, m_got, m_ovf, m_prev, m_known;
    logic [7:0]   m_bank;
    logic [255:0] m_map;
    logic [7:0]   m_sum;
    bit           m_sumv;

    logic [30:0]  wlog[$];      // {mem_A, mem_D} of every acknowledged write
    int           ack_delay = 2;   // >=0: ack after that many cycles of mem_wr; <0: random
    int           ack_pct = 50;
    int           hi_cycles = 0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock: drive ack, compare outputs to model, advance model
    task automatic cycle();
        bit          e_wr, e_wait, pop, acc;
        int          ph, sz0;
        logic [21:0] head;
        logic [22:0] e_A;
        if (ack_delay >= 0) mem_ack = mem_wr && (hi_cycles >= ack_delay);
        else                mem_ack = ($urandom_range(0, 99) < ack_pct);
        #2;
        sz0    = m_q.size();
        e_wr   = (sz0 != 0) && !m_cool;
        head   = e_wr ? m_q[0] : 22'd0;
        e_A    = m_lower ? {9'd0, head[21:8]} : {1'b1, m_bank, head[21:8]};
        pop    = e_wr && mem_ack;
        if (m_phase == P_LOAD) e_wait = (sz0 == DEPTH) && !pop;
        else                   e_wait = (m_phase == P_DRAIN) || (m_phase == P_COMM);
        acc    = (m_phase == P_LOAD) && dl_wr && !e_wait;
        if (m_known) begin
            chk("mem_wr", mem_wr, e_wr);
            if (e_wr) begin
                chk("mem_A", mem_A, e_A);
                chk("mem_D", mem_D, head[7:0]);
            end
            chk("dl_wait", dl_wait, e_wait);
            chk("ovf", ovf, m_ovf);
            chk("rom_map", rom_map, m_map);
`ifdef ROM_CHECKSUM_EN
            chk("rom_sum", rom_sum, m_sum);
            chk("rom_sum_valid", rom_sum_valid, m_sumv);
`endif
        end
        if (mem_wr && mem_ack) wlog.push_back({mem_A, mem_D});
        if (mem_wr && !mem_ack) hi_cycles++;
        else                    hi_cycles = 0;

        if (reset) begin
            m_phase = P_IDLE; m_q.delete(); m_cool = 0; m_ovf = 0; m_map = 256'h1;
            m_prev = 0; m_got = 0; m_sum = 0; m_sumv = 0; m_lower = 0; m_bank = 0;
            m_known = 1;
        end else begin
            ph     = m_phase;
            m_cool = pop;
            if (pop) begin
                m_sum = m_sum + m_q[0][7:0];
                void'(m_q.pop_front());
            end
            if (acc) m_q.push_back({dl_addr, dl_data});
            if (dl_wr && e_wait) m_ovf = 1;
            if (ph == P_IDLE) begin
                if (dl_active && !m_prev) begin
                    m_phase = P_LOAD; m_lower = dl_lower; m_bank = dl_bank;
                    m_got = 0; m_ovf = 0; m_sum = 0; m_sumv = 0;
                    if (!dl_lower) m_map[dl_bank] = 1'b0;
                end
            end else if (ph == P_LOAD) begin
                if (acc) m_got = 1;
                if (!dl_active) m_phase = P_DRAIN;
            end else if (ph == P_DRAIN) begin
                if (sz0 == 0) begin
                    m_phase = P_COMM;
                    m_sumv  = 1;
                end
            end else begin
                if (!m_lower && m_got) m_map[m_bank] = 1'b1;
                m_phase = P_IDLE;
            end
            m_prev = dl_active;
        end
        @(negedge clk);
    endtask

    task automatic start_xfer(input bit lower, input logic [7:0] bank);
        dl_active = 1'b1; dl_lower = lower; dl_bank = bank; dl_wr = 1'b0;
        cycle();
    endtask

    task automatic put(input logic [13:0] a, input logic [7:0] d);
        dl_wr = 1'b1; dl_addr = a; dl_data = d;
        cycle();
        dl_wr = 1'b0;
    endtask

    task automatic end_xfer();
        int n;
        n = 0;
        dl_active = 1'b0; dl_wr = 1'b0;
        cycle();
        while (m_phase != P_IDLE && n < 400) begin
            cycle();
            n++;
        end
        if (n >= 400) begin
            vectors++;
            miscompares++;
            $display("FAIL drain_timeout: got busy after %0d cycles expected idle", n);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1);
    end

    initial begin
        int len, gap;
        repeat (3) cycle();
        reset = 1'b0;
        // Reset values
        chk("rst_rom_map", rom_map, 256'h1);
        chk("rst_mem_wr", mem_wr, 1'b0);
        chk("rst_mem_A", mem_A, 23'd0);
        chk("rst_mem_D", mem_D, 8'd0);
        chk("rst_dl_wait", dl_wait, 1'b0);
        chk("rst_ovf", ovf, 1'b0);

        // Upper bank 7, three bytes, ack two cycles after each request
        ack_delay = 2; wlog.delete();
        start_xfer(1'b0, 8'd7);
        put(14'd0, 8'h11); put(14'd1, 8'h22); put(14'd2, 8'h33);
        end_xfer();
        chk("b7_count", wlog.size(), 3);
        chk("b7_w0", wlog[0], {23'h41C000, 8'h11});
        chk("b7_w1", wlog[1], {23'h41C001, 8'h22});
        chk("b7_w2", wlog[2], {23'h41C002, 8'h33});
        chk("b7_map7", rom_map[7], 1'b1);
        chk("b7_map0", rom_map[0], 1'b1);

        // Lower ROM, last byte
        wlog.delete();
        start_xfer(1'b1, 8'd0);
        put(14'h3FFF, 8'hAA);
        end_xfer();
        chk("low_count", wlog.size(), 1);
        chk("low_w0", wlog[0], {23'h003FFF, 8'hAA});
        chk("low_map", rom_map, 256'h81);

        // Memory stalled: four bytes fill the FIFO, two are dropped
        ack_delay = 20; wlog.delete();
        start_xfer(1'b0, 8'd5);
        for (int i = 0; i < 4; i++) put(14'(i), 8'(8'h50 + i));
        chk("stall_wait", dl_wait, 1'b1);
        put(14'd4, 8'h54); put(14'd5, 8'h55);
        chk("stall_ovf", ovf, 1'b1);
        end_xfer();
        chk("stall_count", wlog.size(), 4);
        chk("stall_w3", wlog[3], {23'h414003, 8'h53});
        chk("stall_ovf_sticky", ovf, 1'b1);
        chk("stall_map5", rom_map[5], 1'b1);

        // Reset while draining with a request on the bus
        ack_delay = 50;
        start_xfer(1'b0, 8'd9);
        put(14'd10, 8'h01); put(14'd11, 8'h02);
        dl_active = 1'b0;
        cycle(); cycle();
        chk("drain_mem_wr", mem_wr, 1'b1);
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        chk("mrst_mem_wr", mem_wr, 1'b0);
        chk("mrst_map", rom_map, 256'h1);
        chk("mrst_wait", dl_wait, 1'b0);

        // Empty transfer invalidates a previously loaded bank
        ack_delay = 1;
        start_xfer(1'b0, 8'd3);
        put(14'd0, 8'h77);
        end_xfer();
        chk("b3_set", rom_map[3], 1'b1);
        start_xfer(1'b0, 8'd3);
        end_xfer();
        chk("b3_clr", rom_map[3], 1'b0);

`ifdef ROM_CHECKSUM_EN
        start_xfer(1'b0, 8'd12);
        put(14'd0, 8'hFF); put(14'd1, 8'h02);
        end_xfer();
        chk("sum_val", rom_sum, 8'h01);
        chk("sum_valid", rom_sum_valid, 1'b1);
`endif

        // Randomized transfers with random ack timing and stray strobes
        ack_delay = -1;
        for (int t = 0; t < 40; t++) begin
            ack_pct   = int'($urandom_range(10, 90));
            dl_lower  = ($urandom_range(0, 3) == 0);
            dl_bank   = 8'($urandom_range(1, 255));
            dl_active = 1'b1;
            len = int'($urandom_range(1, 12));
            for (int c = 0; c < len; c++) begin
                dl_wr   = ($urandom_range(0, 2) != 0);
                dl_addr = 14'($urandom);
                dl_data = 8'($urandom);
                cycle();
            end
            dl_active = 1'b0;
            gap = int'($urandom_range(0, 8));
            for (int c = 0; c < gap; c++) begin
                dl_wr   = ($urandom_range(0, 3) == 0);
                dl_addr = 14'($urandom);
                dl_data = 8'($urandom);
                cycle();
            end
            dl_wr = 1'b0;
        end
        end_xfer();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/amstrad_rom_loader.md
AMSTRAD_ROM_LOADER -- requirements
Module: amstrad_rom_loader

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, byte-buffer depth (power of two, >=2).
REQ-002 CLK  input  1  single clock; all logic rising-edge.
REQ-003 reset  input  1  synchronous, active-high.
REQ-004 dl_active  input  1  download window; high for whole transfer.
REQ-005 dl_lower  input  1  target is lower ROM; sampled on dl_active rise.
REQ-006 dl_bank  input  8  upper ROM bank number; sampled on dl_active rise.
REQ-007 dl_wr  input  1  one-cycle strobe, byte valid.
REQ-008 dl_addr  input  14  byte offset within 16KB ROM.
REQ-009 dl_data  input  8  byte value.
REQ-010 dl_wait  output  1  loader cannot accept dl_wr this cycle.
REQ-011 mem_wr  output  1  write request to SDRAM, level, held until ack.
REQ-012 mem_A  output  23  write byte address.
REQ-013 mem_D  output  8  write byte data.
REQ-014 mem_ack  input  1  one-cycle acceptance of current request.
REQ-015 rom_map  output  256  bit n set = upper ROM bank n present.
REQ-016 ovf  output  1  sticky: byte dropped on dl_wr while dl_wait.

Function
REQ-017 States: IDLE, LOAD, DRAIN, COMMIT.
REQ-018 IDLE->LOAD on dl_active 0->1; latch dl_lower, dl_bank; clear rom_map[dl_bank] unless dl_lower; clear ovf and byte counter.
REQ-019 LOAD: dl_wr && !dl_wait pushes {dl_addr, dl_data} into FIFO; byte counter increments, saturating at 1.
REQ-020 LOAD->DRAIN on dl_active 1->0; DRAIN->COMMIT when FIFO empty and no request outstanding; COMMIT->IDLE after one cycle.
REQ-021 COMMIT sets rom_map[bank] iff !lower and at least one byte accepted; otherwise rom_map unchanged.
REQ-022 dl_wait = FIFO full, or state is DRAIN/COMMIT; dl_wait = 0 in IDLE and in LOAD when not full.
REQ-023 dl_wr with dl_wait high: byte dropped, ovf set; dl_wr in IDLE ignored, ovf unchanged.
REQ-024 dl_active rise in DRAIN/COMMIT ignored; a new transfer starts only on a rise seen in IDLE.
REQ-025 Address: lower -> mem_A = {9'b0, addr}; upper -> mem_A = {1'b1, bank, addr}.
REQ-026 Byte pushed into empty FIFO in cycle N -> mem_wr, mem_A, mem_D valid in cycle N+1.
REQ-027 mem_A, mem_D stable while mem_wr high; entry popped on cycle mem_ack seen; mem_wr low at least one cycle after each ack.
REQ-028 Simultaneous push and pop on full FIFO: pop then push, no drop, dl_wait low that cycle only if not full after pop.
REQ-029 Write order to memory equals acceptance order; no byte duplicated.
REQ-030 mem_ack while mem_wr low ignored.

Reset
REQ-031 reset: state IDLE, FIFO flushed, mem_wr 0, mem_A 0, mem_D 0, dl_wait 0, ovf 0, rom_map 256'h1 (bank 0 always present).
REQ-032 reset mid-transfer: outstanding request abandoned, no COMMIT, rom_map returns to 256'h1 next cycle.

Configuration
REQ-033 Macro ROM_CHECKSUM_EN defined: output rom_sum[7:0], 8-bit modulo sum of bytes acknowledged by memory, cleared on LOAD entry, frozen from COMMIT; plus rom_sum_valid high from COMMIT until next LOAD entry or reset; both 0 on reset.
REQ-034 Macro undefined: rom_sum and rom_sum_valid ports absent; no adder logic.

Structure
REQ-035 Shared package amstrad_mem_pkg: state enum, LOWER_ROM_PREFIX (9'b0), UPPER_ROM_FLAG (1'b1), RAM/ROM address width 23.
REQ-036 One sub-module amstrad_loader_fifo: synchronous FIFO, FIFO_DEPTH x 22 bits, full/empty, push/pop same cycle.

Verification
REQ-037 Upper load bank 7, 3 bytes 0x11,0x22,0x33 at 0..2, ack 2 cycles after each mem_wr -> mem_A 0x41C000..0x41C002, data in order, rom_map[7]=1 after COMMIT, rom_map[0]=1.
REQ-038 Lower load, 1 byte 0xAA at 0x3FFF -> mem_A 0x003FFF, rom_map unchanged.
REQ-039 mem_ack held off 20 cycles, 6 dl_wr back-to-back -> dl_wait high after 4th push, bytes 5-6 dropped, ovf=1, only 4 writes issued.
REQ-040 dl_active pulse with no dl_wr on bank 3 previously set -> rom_map[3]=0 after COMMIT.
REQ-041 reset asserted in DRAIN with mem_wr high -> next cycle mem_wr 0, rom_map 256'h1, state IDLE.
REQ-042 ROM_CHECKSUM_EN: bytes 0xFF,0x02 -> rom_sum 0x01, rom_sum_valid 1 after COMMIT.
